// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - load/store pipeline stage between execute and writeback
package memory_stage_pkg;

    typedef enum logic [3:0] {
        OP_ALU = 4'd0,
        OP_LB  = 4'd1,
        OP_LH  = 4'd2,
        OP_LW  = 4'd3,
        OP_LD  = 4'd4,
        OP_LBU = 4'd5,
        OP_LHU = 4'd6,
        OP_LWU = 4'd7,
        OP_SB  = 4'd8,
        OP_SH  = 4'd9,
        OP_SW  = 4'd10,
        OP_SD  = 4'd11
    } mem_op_t;

    typedef struct packed {
        mem_op_t op;
        logic    regwrite;
    } ctl_t;

    typedef struct packed {
        ctl_t        ctl;
        logic [4:0]  dst;
        logic [31:0] instr;
        logic [63:0] aluout;
        logic [63:0] rd;
    } exec_data_t;

    typedef struct packed {
        logic [31:0] instr;
        ctl_t        ctl;
        logic [4:0]  dst;
        logic [63:0] result;
    } mem_data_t;

endpackage

module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter int BUS_BYTES = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  exec_data_t           dataE,
    output logic                 dreq_valid,
    output logic [XLEN-1:0]      dreq_addr,
    output logic [2:0]           dreq_size,
    output logic [BUS_BYTES-1:0] dreq_strobe,
    output logic [XLEN-1:0]      dreq_data,
    input  logic                 dresp_addr_ok,
    input  logic                 dresp_data_ok,
    input  logic [XLEN-1:0]      dresp_data,
    output logic                 out_valid,
    output mem_data_t            dataM,
    output logic                 misalign
);

    localparam int OFFW = $clog2(BUS_BYTES);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [31:0]     lat_instr;
    ctl_t            lat_ctl;
    logic [4:0]      lat_dst;
    logic [XLEN-1:0] lat_addr;
    logic [XLEN-1:0] lat_rd;

    logic            accept;
    logic            in_is_mem;
    logic            in_aligned;
    logic [2:0]      in_size;
    logic [2:0]      lat_size;
    logic            lat_is_store;
    logic [OFFW-1:0] lat_off;
    logic [XLEN-1:0] raw;
    logic [XLEN-1:0] load_val;

    // Address acceptance is informational only: the request is held until data_ok.
    logic unused_addr_ok;
    assign unused_addr_ok = dresp_addr_ok;

    function automatic logic [2:0] op_size(input mem_op_t op);
        case (op)
            OP_LB, OP_LBU, OP_SB: op_size = 3'd0;
            OP_LH, OP_LHU, OP_SH: op_size = 3'd1;
            OP_LW, OP_LWU, OP_SW: op_size = 3'd2;
            default:              op_size = 3'd3;
        endcase
    endfunction

    function automatic logic op_is_store(input mem_op_t op);
        op_is_store = (op == OP_SB) || (op == OP_SH) || (op == OP_SW) || (op == OP_SD);
    endfunction

    // Decode of the incoming op: memory or not, access size, natural alignment
    always_comb begin
        in_is_mem  = (dataE.ctl.op != OP_ALU);
        in_size    = op_size(dataE.ctl.op);
        in_aligned = 1'b1;
        case (in_size)
            3'd1:    in_aligned = (dataE.aluout[0] == 1'b0);
            3'd2:    in_aligned = (dataE.aluout[1:0] == 2'b00);
            3'd3:    in_aligned = (dataE.aluout[2:0] == 3'b000);
            default: in_aligned = 1'b1;
        endcase
    end

    assign in_ready     = (state_q == IDLE);
    assign accept       = in_valid & in_ready;
    assign lat_size     = op_size(lat_ctl.op);
    assign lat_is_store = op_is_store(lat_ctl.op);
    assign lat_off      = lat_addr[OFFW-1:0];

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and bus request outputs driven from the latched copy while in REQ
    always_comb begin
        state_d     = state_q;
        dreq_valid  = 1'b0;
        dreq_addr   = lat_addr;
        dreq_size   = lat_size;
        dreq_strobe = '0;
        dreq_data   = lat_rd << {lat_off, 3'b000};
        case (state_q)
            IDLE: begin
                if (accept && in_is_mem && in_aligned) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                dreq_valid = 1'b1;
                if (lat_is_store) begin
                    dreq_strobe = ((BUS_BYTES)'((16'd1 << (16'd1 << lat_size)) - 16'd1)) << lat_off;
                end
                if (dresp_data_ok) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Lane-shift the raw response and extend it according to the load type
    always_comb begin
        raw      = dresp_data >> {lat_off, 3'b000};
        load_val = '0;
        case (lat_ctl.op)
            OP_LB:   load_val = {{(XLEN-8){raw[7]}}, raw[7:0]};
            OP_LH:   load_val = {{(XLEN-16){raw[15]}}, raw[15:0]};
            OP_LW:   load_val = {{(XLEN-32){raw[31]}}, raw[31:0]};
            OP_LBU:  load_val = {{(XLEN-8){1'b0}}, raw[7:0]};
            OP_LHU:  load_val = {{(XLEN-16){1'b0}}, raw[15:0]};
            OP_LWU:  load_val = {{(XLEN-32){1'b0}}, raw[31:0]};
            OP_LD:   load_val = raw;
            default: load_val = '0;
        endcase
    end

    // Latch accepted memory ops and produce the one-cycle writeback pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            misalign  <= 1'b0;
            dataM     <= '0;
            lat_instr <= '0;
            lat_ctl   <= '0;
            lat_dst   <= '0;
            lat_addr  <= '0;
            lat_rd    <= '0;
        end else begin
            out_valid <= 1'b0;
            misalign  <= 1'b0;
            if (state_q == IDLE && accept) begin
                if (!in_is_mem) begin
                    out_valid    <= 1'b1;
                    dataM.instr  <= dataE.instr;
                    dataM.ctl    <= dataE.ctl;
                    dataM.dst    <= dataE.dst;
                    dataM.result <= dataE.aluout;
                end else if (!in_aligned) begin
                    out_valid    <= 1'b1;
                    misalign     <= 1'b1;
                    dataM.instr  <= dataE.instr;
                    dataM.ctl    <= dataE.ctl;
                    dataM.dst    <= dataE.dst;
                    dataM.result <= '0;
                end else begin
                    lat_instr <= dataE.instr;
                    lat_ctl   <= dataE.ctl;
                    lat_dst   <= dataE.dst;
                    lat_addr  <= dataE.aluout;
                    lat_rd    <= dataE.rd;
                end
            end else if (state_q == REQ && dresp_data_ok) begin
                out_valid    <= 1'b1;
                dataM.instr  <= lat_instr;
                dataM.ctl    <= lat_ctl;
                dataM.dst    <= lat_dst;
                dataM.result <= lat_is_store ? '0 : load_val;
            end
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - directed self-checking bench for memory_stage
module tb_memory_stage;
    import memory_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    exec_data_t  dataE;
    logic        dreq_valid;
    logic [63:0] dreq_addr;
    logic [2:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic [63:0] dreq_data;
    logic        dresp_addr_ok;
    logic        dresp_data_ok;
    logic [63:0] dresp_data;
    logic        out_valid;
    mem_data_t   dataM;
    logic        misalign;

    int n_checks = 0;
    int n_fail   = 0;

    memory_stage #(.XLEN(64), .BUS_BYTES(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .dataE         (dataE),
        .dreq_valid    (dreq_valid),
        .dreq_addr     (dreq_addr),
        .dreq_size     (dreq_size),
        .dreq_strobe   (dreq_strobe),
        .dreq_data     (dreq_data),
        .dresp_addr_ok (dresp_addr_ok),
        .dresp_data_ok (dresp_data_ok),
        .dresp_data    (dresp_data),
        .out_valid     (out_valid),
        .dataM         (dataM),
        .misalign      (misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input mem_op_t op, input logic [4:0] dst, input logic [63:0] addr,
                         input logic [63:0] rd);
        in_valid          = 1'b1;
        dataE.ctl.op      = op;
        dataE.ctl.regwrite = 1'b1;
        dataE.dst         = dst;
        dataE.instr       = {28'h0, op};
        dataE.aluout      = addr;
        dataE.rd          = rd;
    endtask

    initial begin
        reset         = 1'b1;
        in_valid      = 1'b0;
        dataE         = '0;
        dresp_addr_ok = 1'b0;
        dresp_data_ok = 1'b0;
        dresp_data    = '0;
        tick();
        tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_misalign", misalign, 0);
        chk("rst_dreq_valid", dreq_valid, 0);
        chk("rst_dreq_strobe", dreq_strobe, 0);
        chk("rst_dataM", dataM, 0);
        chk("rst_in_ready", in_ready, 1);
        reset = 1'b0;

        // reset while a request is outstanding
        drive(OP_LD, 5'd1, 64'h2000, 64'h0);
        tick();
        in_valid = 1'b0;
        chk("midrst_req_valid", dreq_valid, 1);
        chk("midrst_in_ready", in_ready, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_dreq_dropped", dreq_valid, 0);
        chk("midrst_out_valid", out_valid, 0);
        dresp_data_ok = 1'b1;
        dresp_data    = 64'hDEAD;
        tick();
        dresp_data_ok = 1'b0;
        chk("late_ok_no_out", out_valid, 0);
        tick();
        chk("late_ok_no_out2", out_valid, 0);

        // ALU pass-through
        drive(OP_ALU, 5'd7, 64'h1234, 64'h0);
        chk("add_no_req_pre", dreq_valid, 0);
        tick();
        in_valid = 1'b0;
        chk("add_out_valid", out_valid, 1);
        chk("add_result", dataM.result, 64'h1234);
        chk("add_dst", dataM.dst, 5'd7);
        chk("add_no_req", dreq_valid, 0);
        tick();
        chk("add_pulse_ends", out_valid, 0);

        // LB with three wait cycles
        drive(OP_LB, 5'd3, 64'h8000_0003, 64'h0);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("lb_wait_valid", dreq_valid, 1);
            chk("lb_wait_addr", dreq_addr, 64'h8000_0003);
            chk("lb_wait_size", dreq_size, 3'd0);
            chk("lb_wait_strobe", dreq_strobe, 8'h00);
            chk("lb_wait_in_ready", in_ready, 0);
            chk("lb_wait_no_out", out_valid, 0);
            tick();
        end
        dresp_data_ok = 1'b1;
        dresp_data    = 64'h0000_0000_80FF_0000;
        chk("lb_last_valid", dreq_valid, 1);
        chk("lb_last_addr", dreq_addr, 64'h8000_0003);
        chk("lb_last_in_ready", in_ready, 0);
        tick();
        dresp_data_ok = 1'b0;
        chk("lb_out_valid", out_valid, 1);
        chk("lb_result", dataM.result, 64'hFFFF_FFFF_FFFF_FF80);
        chk("lb_misalign", misalign, 0);
        chk("lb_in_ready", in_ready, 1);
        chk("lb_req_gone", dreq_valid, 0);

        // SH into the top half-word of the lane
        drive(OP_SH, 5'd0, 64'h1006, 64'hABCD);
        tick();
        in_valid = 1'b0;
        chk("sh_valid", dreq_valid, 1);
        chk("sh_strobe", dreq_strobe, 8'hC0);
        chk("sh_data", dreq_data, 64'hABCD_0000_0000_0000);
        chk("sh_size", dreq_size, 3'd1);
        dresp_data_ok = 1'b1;
        tick();
        dresp_data_ok = 1'b0;
        chk("sh_out_valid", out_valid, 1);
        chk("sh_result", dataM.result, 64'h0);

        // misaligned LW
        drive(OP_LW, 5'd4, 64'h1002, 64'h0);
        tick();
        in_valid = 1'b0;
        chk("lw_mis_no_req", dreq_valid, 0);
        chk("lw_mis_out_valid", out_valid, 1);
        chk("lw_mis_flag", misalign, 1);
        chk("lw_mis_result", dataM.result, 64'h0);
        tick();
        chk("lw_mis_flag_clr", misalign, 0);

        // LWU completing in the request cycle
        drive(OP_LWU, 5'd5, 64'h1004, 64'h0);
        tick();
        in_valid      = 1'b0;
        dresp_data_ok = 1'b1;
        dresp_data    = 64'hF000_0000_0000_0000;
        chk("lwu_valid", dreq_valid, 1);
        chk("lwu_size", dreq_size, 3'd2);
        tick();
        dresp_data_ok = 1'b0;
        chk("lwu_out_valid", out_valid, 1);
        chk("lwu_result", dataM.result, 64'h0000_0000_F000_0000);

        // back-to-back LD then ADD
        drive(OP_LD, 5'd8, 64'h3000, 64'h0);
        tick();
        in_valid      = 1'b0;
        dresp_data_ok = 1'b1;
        dresp_data    = 64'h1122_3344_5566_7788;
        chk("ld_size", dreq_size, 3'd3);
        tick();
        dresp_data_ok = 1'b0;
        drive(OP_ALU, 5'd9, 64'h55, 64'h0);
        chk("ld_out_valid", out_valid, 1);
        chk("ld_result", dataM.result, 64'h1122_3344_5566_7788);
        chk("b2b_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("b2b_add_valid", out_valid, 1);
        chk("b2b_add_result", dataM.result, 64'h55);
        chk("b2b_add_dst", dataM.dst, 5'd9);
        tick();
        chk("b2b_idle", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Pipeline stage directly downstream of the execute stage.
- Consumes one exec_data_t per accepted transfer and performs LB/LH/LW/LD/LBU/LHU/LWU/SB/SH/SW/SD over the data bus.
- Produces a registered mem_data_t result for writeback; non-memory ops pass through with the ALU result.
- Back-pressures execute while a bus transaction is outstanding.

Parameters:
- XLEN, 64, data/address width.
- BUS_BYTES, 8, data-bus width in bytes (strobe width).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  dataE carries a valid instruction
- in_ready  out  1  stage accepts dataE this cycle
- dataE  in  exec_data_t  ctl, dst, instr, aluout (address/result), rd (store data)
- dreq_valid  out  1  bus request valid
- dreq_addr  out  64  byte address
- dreq_size  out  3  msize_t: 0=1B, 1=2B, 2=4B, 3=8B
- dreq_strobe  out  8  byte-write enables, 0 for loads
- dreq_data  out  64  lane-aligned store data
- dresp_addr_ok  in  1  address accepted (informational; the request stays held)
- dresp_data_ok  in  1  transaction complete
- dresp_data  in  64  raw load data, full 8-byte lane
- out_valid  out  1  dataM valid, one-cycle pulse per instruction
- dataM  out  mem_data_t  instr, ctl, dst, result
- misalign  out  1  pulses with out_valid when the access was misaligned

Behaviour:
- Reset: state=IDLE. out_valid=0, misalign=0, dreq_valid=0, dreq_strobe=0, dataM=0.
- Reset mid-transaction: dreq_valid=0 from the cycle after the reset edge. A late dresp_data_ok is ignored.
- FSM states: IDLE, REQ.
- in_ready = (state==IDLE).
- Accept condition: in_valid & in_ready.
- IDLE, accepted non-memory op: dataM.result = aluout. out_valid=1 the next cycle (latency 1). Stay IDLE.
- IDLE, accepted memory op, aligned: latch instr, ctl, dst, addr=aluout, store data=rd. Go to REQ.
- Alignment rule: addr mod size == 0.
- IDLE, accepted memory op, misaligned: no bus request. Next cycle out_valid=1, misalign=1, result=0. Stay IDLE.
- REQ: dreq_valid=1 with all dreq_* fields constant from the latched copy until the cycle dresp_data_ok=1 (inclusive).
- REQ, data_ok same cycle as the request: allowed; completes in one REQ cycle.
- REQ, on dresp_data_ok: return to IDLE. Next cycle out_valid=1 with the load result (stores: result=0).
- Latency: minimum 2 cycles from accept to out_valid for memory ops.
- in_ready=0 throughout REQ. It returns to 1 in the cycle out_valid is asserted, so back-to-back accepts are possible.
- Lane alignment: off=addr[2:0]. dreq_addr = full addr.
- Store strobe = mask(size) << off: 0x01, 0x03, 0x0F, 0xFF.
- Store data = rd << (8*off).
- Load: raw = dresp_data >> (8*off), truncated to size.
- Load extension: LB/LH/LW sign-extend to 64. LBU/LHU/LWU zero-extend. LD uses raw unchanged.
- out_valid is registered and never combinationally depends on in_valid.
- Writeback never stalls.

Test Plan:
- Reset pulse while in REQ -> next cycle dreq_valid=0, out_valid=0. A following dresp_data_ok=1 produces no out_valid.
- ADD with aluout=0x1234 -> one cycle later out_valid=1, result=0x1234, no dreq_valid.
- LB, addr=0x80000003, dresp_data=0x00000000_80FF0000 after 3 wait cycles -> dreq_size=0, strobe=0. dreq fields stable 4 cycles. Result=0xFFFFFFFF_FFFFFF80. in_ready=0 until completion.
- SH, addr=0x1006, rd=0xABCD -> dreq_strobe=0xC0, dreq_data=0xABCD0000_00000000, dreq_size=1. Result=0.
- LW, addr=0x1002 -> no dreq_valid. Next cycle out_valid=1, misalign=1.
- LWU, addr=0x1004, data_ok same cycle as the request, dresp_data=0xF0000000_00000000 -> result=0x00000000_F0000000.
- Back-to-back LD then ADD -> ADD accepted in the LD's out_valid cycle. ADD out_valid on the following cycle.
